// File: rtl/traffic_lamp_renderer.sv
// Two-stage VGA lamp renderer: draws a row of square lamps coloured from a
// per-frame latched state code, with an optional frame-counted blink.
module traffic_lamp_renderer #(
  parameter int unsigned NUM_LAMPS    = 3,
  parameter int unsigned LAMP_SIZE    = 80,
  parameter int unsigned LAMP_PITCH   = 225,
  parameter int unsigned ORIGIN_X     = 50,
  parameter int unsigned ORIGIN_Y     = 350,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [3:0]  OFF_LEVEL    = 4'h3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_tick,
  input  logic                   video_on,
  input  logic                   frame_start,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [2*NUM_LAMPS-1:0] lamp_state,
  input  logic [NUM_LAMPS-1:0]   lamp_blink,
  output logic                   shape_active,
  output logic [3:0]             shape_r,
  output logic [3:0]             shape_g,
  output logic [3:0]             shape_b
);

  localparam int unsigned IDX_W = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned CW    = 12;

  localparam logic [CW-1:0]    Y_LO     = CW'(ORIGIN_Y);
  localparam logic [CW-1:0]    Y_HI     = CW'(ORIGIN_Y + LAMP_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] CODE_OFF    = 2'b00;
  localparam logic [1:0] CODE_RED    = 2'b01;
  localparam logic [1:0] CODE_YELLOW = 2'b10;
  localparam logic [1:0] CODE_GREEN  = 2'b11;

  function automatic logic [CW-1:0] lamp_lo(input int unsigned i);
    return CW'(ORIGIN_X + i * LAMP_PITCH);
  endfunction

  function automatic logic [CW-1:0] lamp_hi(input int unsigned i);
    return CW'(ORIGIN_X + i * LAMP_PITCH + LAMP_SIZE);
  endfunction

  logic [2*NUM_LAMPS-1:0] shadow_state;
  logic [NUM_LAMPS-1:0]   shadow_blink;
  logic [CNT_W-1:0]       blink_cnt;
  logic                   blink_phase;

  logic                   s1_valid;
  logic                   s1_hit;
  logic [IDX_W-1:0]       s1_idx;
  logic                   s1_video;

  logic [CW-1:0]          x_ext_c;
  logic [CW-1:0]          y_ext_c;
  logic                   y_in_row_c;
  logic                   hit_c;
  logic [IDX_W-1:0]       idx_c;

  logic [1:0]             sel_code_c;
  logic                   sel_blink_c;
  logic                   lit_c;
  logic                   shown_c;
  logic [3:0]             r_c;
  logic [3:0]             g_c;
  logic [3:0]             b_c;

  // Lamp state is latched only at frame boundaries so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_state <= '0;
      shadow_blink <= '0;
    end else if (frame_start) begin
      shadow_state <= lamp_state;
      shadow_blink <= lamp_blink;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // Bounds are widened to 12 bits so lamps past column 1023 cannot wrap.
  assign x_ext_c    = {2'b00, x};
  assign y_ext_c    = {2'b00, y};
  assign y_in_row_c = (y_ext_c >= Y_LO) && (y_ext_c < Y_HI);

  // Lowest-numbered lamp wins when lamps overlap.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
      if (!hit_c && y_in_row_c && (x_ext_c >= lamp_lo(i)) && (x_ext_c < lamp_hi(i))) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
      s1_video <= 1'b0;
    end else if (pixel_tick) begin
      s1_valid <= 1'b1;
      s1_hit   <= hit_c;
      s1_idx   <= idx_c;
      s1_video <= video_on;
    end
  end

  // Index compare against each lamp keeps the shadow read in range.
  always_comb begin
    sel_code_c  = CODE_OFF;
    sel_blink_c = 1'b0;
    for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
      if (s1_idx == IDX_W'(i)) begin
        sel_code_c  = shadow_state[2*i +: 2];
        sel_blink_c = shadow_blink[i];
      end
    end
  end

  assign lit_c   = (sel_code_c != CODE_OFF) && (!sel_blink_c || blink_phase);
  assign shown_c = s1_valid && s1_video && s1_hit;

  always_comb begin
    r_c = 4'h0;
    g_c = 4'h0;
    b_c = 4'h0;
    if (shown_c) begin
      if (lit_c) begin
        unique case (sel_code_c)
          CODE_RED:    r_c = 4'hF;
          CODE_YELLOW: begin
            r_c = 4'hF;
            g_c = 4'hF;
          end
          CODE_GREEN:  g_c = 4'hF;
          default: begin
            r_c = 4'h0;
            g_c = 4'h0;
            b_c = 4'h0;
          end
        endcase
      end else begin
        r_c = OFF_LEVEL;
        g_c = OFF_LEVEL;
        b_c = OFF_LEVEL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shape_active <= 1'b0;
      shape_r      <= 4'h0;
      shape_g      <= 4'h0;
      shape_b      <= 4'h0;
    end else if (pixel_tick) begin
      shape_active <= shown_c;
      shape_r      <= r_c;
      shape_g      <= g_c;
      shape_b      <= b_c;
    end
  end

endmodule

// File: tb/tb_traffic_lamp_renderer.sv
// Scoreboard bench for traffic_lamp_renderer: the driver queues hand-computed
// expectations per pixel tick, the monitor pops them as results emerge.
module tb_traffic_lamp_renderer;

  localparam logic [12:0] E_NONE = 13'h0000;
  localparam logic [12:0] E_RED  = 13'h1F00;
  localparam logic [12:0] E_YEL  = 13'h1FF0;
  localparam logic [12:0] E_GRN  = 13'h10F0;
  localparam logic [12:0] E_OFF  = 13'h1333;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_tick;
  logic       video_on;
  logic       frame_start;
  logic [9:0] x;
  logic [9:0] y;
  logic [5:0] lamp_state;
  logic [2:0] lamp_blink;

  logic       sa, sa4;
  logic [3:0] r, g, b, r4, g4, b4;

  traffic_lamp_renderer dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .frame_start(frame_start), .x(x), .y(y), .lamp_state(lamp_state),
    .lamp_blink(lamp_blink), .shape_active(sa), .shape_r(r), .shape_g(g), .shape_b(b)
  );

  // Four lamps at pitch 300: lamp 3 spans x=950..1029 and is forced green.
  traffic_lamp_renderer #(.NUM_LAMPS(4), .LAMP_PITCH(300)) dut4 (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .frame_start(frame_start), .x(x), .y(y), .lamp_state({2'b11, lamp_state}),
    .lamp_blink({1'b0, lamp_blink}), .shape_active(sa4), .shape_r(r4), .shape_g(g4),
    .shape_b(b4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] exp;
    bit          chk4;
    logic [12:0] exp4;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [12:0] last, last4;
  bit          last4_ok;

  task automatic cmp(input string nm, input logic [12:0] a, input logic [12:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got active=%0b rgb=%03h, expected active=%0b rgb=%03h",
               nm, a[12], a[11:0], e[12], e[11:0]);
    end
  endtask

  // Output after pixel tick k belongs to the pixel issued at tick k-1.
  initial begin : monitor
    exp_t e;
    bit   rst_s, tk_s;
    last = '0; last4 = '0; last4_ok = 1'b1;
    forever begin
      @(posedge clk);
      rst_s = reset;
      tk_s  = pixel_tick;
      #1;
      if (rst_s) begin
        cmp("reset", {sa, r, g, b}, E_NONE);
        cmp("reset4", {sa4, r4, g4, b4}, E_NONE);
        last = '0; last4 = '0; last4_ok = 1'b1;
      end else if (tk_s) begin
        if (sb.size() >= 2) begin
          e = sb.pop_front();
          cmp(e.name, {sa, r, g, b}, e.exp);
          last = e.exp;
          if (e.chk4) cmp({e.name, "_d4"}, {sa4, r4, g4, b4}, e.exp4);
          last4    = e.exp4;
          last4_ok = e.chk4;
        end else begin
          cmp("fill", {sa, r, g, b}, E_NONE);
          cmp("fill4", {sa4, r4, g4, b4}, E_NONE);
          last = '0; last4 = '0; last4_ok = 1'b1;
        end
      end else begin
        cmp("hold", {sa, r, g, b}, last);
        if (last4_ok) cmp("hold4", {sa4, r4, g4, b4}, last4);
      end
    end
  end

  task automatic pix4(input int px, input int py, input bit vo, input bit fs,
                      input logic [12:0] e, input string nm, input bit c4,
                      input logic [12:0] e4);
    @(negedge clk);
    reset       = 1'b0;
    pixel_tick  = 1'b1;
    frame_start = fs;
    video_on    = vo;
    x           = 10'(px);
    y           = 10'(py);
    sb.push_back('{exp: e, chk4: c4, exp4: e4, name: nm});
  endtask

  task automatic pix(input int px, input int py, input bit vo, input bit fs,
                     input logic [12:0] e, input string nm);
    pix4(px, py, vo, fs, e, nm, 1'b0, E_NONE);
  endtask

  task automatic idle(input int n, input bit fs);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset       = 1'b0;
      pixel_tick  = 1'b0;
      frame_start = fs;
    end
  endtask

  task automatic flush();
    pix4(0, 0, 1'b0, 1'b0, E_NONE, "flush", 1'b1, E_NONE);
    pix4(0, 0, 1'b0, 1'b0, E_NONE, "flush", 1'b1, E_NONE);
  endtask

  task automatic do_reset(input int px, input int py);
    @(negedge clk);
    reset       = 1'b1;
    pixel_tick  = 1'b1;
    frame_start = 1'b0;
    video_on    = 1'b1;
    x           = 10'(px);
    y           = 10'(py);
    sb.delete();
  endtask

  typedef struct {
    int          px;
    int          py;
    logic [12:0] e;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : stimulus
    vec_t bvec[8];
    bit   lit;
    reset = 1'b1; pixel_tick = 1'b0; frame_start = 1'b0; video_on = 1'b0;
    x = '0; y = '0; lamp_state = '0; lamp_blink = '0;
    @(negedge clk);
    @(negedge clk);

    // Basic colours and a gap between lamps.
    lamp_state = 6'b11_10_01;
    idle(1, 1'b1);
    pix(60,  360, 1'b1, 1'b0, E_RED,  "t1_lamp0_red");
    pix(285, 360, 1'b1, 1'b0, E_YEL,  "t1_lamp1_yel");
    pix(510, 360, 1'b1, 1'b0, E_GRN,  "t1_lamp2_grn");
    pix(140, 360, 1'b1, 1'b0, E_NONE, "t1_gap");
    flush();

    // Mid-frame change is invisible until the next frame_start.
    lamp_state = 6'b01_01_11;
    pix(60,  360, 1'b1, 1'b0, E_RED, "t2_nolatch0");
    pix(285, 360, 1'b1, 1'b0, E_YEL, "t2_nolatch1");
    pix(60,  360, 1'b1, 1'b0, E_RED, "t2_stage2_on_fs");
    pix(285, 360, 1'b1, 1'b1, E_RED, "t2_issued_on_fs");
    pix(60,  360, 1'b1, 1'b0, E_GRN, "t2_new0");
    pix(510, 360, 1'b1, 1'b0, E_RED, "t2_new2");
    flush();

    // Stall holds outputs; video_on low blanks a lamp pixel.
    pix(60,  360, 1'b1, 1'b0, E_GRN, "t4_pre_stall");
    pix(285, 360, 1'b1, 1'b0, E_RED, "t4_in_stage1");
    idle(5, 1'b0);
    pix(510, 360, 1'b1, 1'b0, E_RED,  "t4_post_stall");
    pix(60,  360, 1'b0, 1'b0, E_NONE, "t4_video_off");
    flush();

    // Lamp 0 edges.
    lamp_state = 6'b11_10_01;
    idle(1, 1'b1);
    bvec[0] = '{49, 360, E_NONE}; bvec[1] = '{50, 360, E_RED};
    bvec[2] = '{129, 360, E_RED}; bvec[3] = '{130, 360, E_NONE};
    bvec[4] = '{60, 349, E_NONE}; bvec[5] = '{60, 350, E_RED};
    bvec[6] = '{60, 429, E_RED};  bvec[7] = '{60, 430, E_NONE};
    foreach (bvec[i])
      pix(bvec[i].px, bvec[i].py, 1'b1, 1'b0, bvec[i].e, $sformatf("t5_edge_x%0d_y%0d", bvec[i].px, bvec[i].py));

    // Four-lamp instance: lamp 3 must render up to column 1023 without wrapping.
    pix4(60,  360, 1'b1, 1'b0, E_RED,  "t5_d4_lamp0", 1'b1, E_RED);
    pix4(949, 360, 1'b1, 1'b0, E_NONE, "t5_d4_x949", 1'b1, E_NONE);
    for (int xx = 950; xx <= 1023; xx += 8)
      pix4(xx, 360, 1'b1, 1'b0, E_NONE, $sformatf("t5_d4_x%0d", xx), 1'b1, E_GRN);
    pix4(1023, 360, 1'b1, 1'b0, E_NONE, "t5_d4_x1023", 1'b1, E_GRN);
    pix4(1000, 430, 1'b1, 1'b0, E_NONE, "t5_d4_below", 1'b1, E_NONE);
    pix4(0,    360, 1'b1, 1'b0, E_NONE, "t5_d4_x0", 1'b1, E_NONE);
    flush();

    // Blink on lamp 0; frame n is the frame after the n-th frame_start since reset.
    do_reset(0, 0);
    lamp_state = 6'b11_10_01;
    lamp_blink = 3'b001;
    for (int n = 1; n < 120; n++) begin
      idle(1, 1'b1);
      lit = ((n / 30) % 2) == 0;
      pix(60,  360, 1'b1, 1'b0, lit ? E_RED : E_OFF, $sformatf("t3_f%0d_lamp0", n));
      pix(285, 360, 1'b1, 1'b0, E_YEL, $sformatf("t3_f%0d_lamp1", n));
      pix(510, 360, 1'b1, 1'b0, E_GRN, $sformatf("t3_f%0d_lamp2", n));
      flush();
    end

    // Reset while a lit lamp is on the outputs; blink phase is left in its dark half.
    pix(285, 360, 1'b1, 1'b0, E_YEL, "t6_lit");
    pix(285, 360, 1'b1, 1'b0, E_YEL, "t6_lit_dropped");
    do_reset(285, 360);
    pix(60,  360, 1'b1, 1'b0, E_OFF, "t6_off0");
    pix(285, 360, 1'b1, 1'b0, E_OFF, "t6_off1");
    pix(510, 360, 1'b1, 1'b0, E_OFF, "t6_off2");
    flush();
    idle(1, 1'b1);
    pix(60,  360, 1'b1, 1'b0, E_RED, "t6_phase_lit");
    flush();
    idle(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
